// File: rtl/rock_spawner.sv
// Rock obstacle game state: lane spawn after a random delay, per-frame fall, retire on exit or hit, speed ramp.
// Optional macro ROCK_LANE_AVOID_EN: consecutive rocks never reuse the previous lane.
module rock_spawner #(
  parameter logic [9:0]  LANE0_X        = 10'd220,
  parameter logic [9:0]  LANE1_X        = 10'd320,
  parameter logic [9:0]  LANE2_X        = 10'd420,
  parameter logic [9:0]  SCREEN_H       = 10'd480,
  parameter logic [9:0]  TICK_LINE      = 10'd480,
  parameter logic [3:0]  SPEED_INIT     = 4'd2,
  parameter logic [3:0]  SPEED_MAX      = 4'd8,
  parameter logic [3:0]  SPEED_UP_EVERY = 4'd4,
  parameter logic [7:0]  SPAWN_DELAY    = 8'd30,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       run,
  input  logic       hit,
  output logic [9:0] rock_x_center,
  output logic [9:0] rock_y_top,
  output logic       rock_active,
  output logic       rock_passed,
  output logic [3:0] speed
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FALL} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_lfsr;
  logic        r_tick;
  logic [7:0]  r_delay, w_delay_nxt;
  logic [3:0]  r_pass_cnt, w_pass_cnt_nxt;
  logic [1:0]  r_prev_lane, w_prev_lane_nxt;
  logic [9:0]  r_x, w_x_nxt;
  logic [9:0]  r_y, w_y_nxt;
  logic        r_active, w_active_nxt;
  logic        r_passed, w_passed_nxt;
  logic [3:0]  r_speed, w_speed_nxt;

  logic [15:0] w_lfsr_shift, w_lfsr_nxt;
  logic [7:0]  w_reload;
  logic [1:0]  w_lane_map, w_lane;
  logic [9:0]  w_lane_x;
  logic [10:0] w_y_sum;
  logic        w_exit;
  logic [3:0]  w_pass_inc;
  logic [3:0]  w_speed_inc;

  // Galois shift; the seed reload only guards against a lock-up state that a nonzero seed never reaches
  assign w_lfsr_shift = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_lfsr_nxt   = (w_lfsr_shift == 16'h0000) ? LFSR_SEED : w_lfsr_shift;
  assign w_reload     = SPAWN_DELAY + {3'b000, r_lfsr[4:0]};
  assign w_lane_map   = (r_lfsr[1:0] == 2'd3) ? 2'd1 : r_lfsr[1:0];

`ifdef ROCK_LANE_AVOID_EN
  assign w_lane = (w_lane_map != r_prev_lane) ? w_lane_map :
                  (w_lane_map == 2'd2)        ? 2'd0 : w_lane_map + 2'd1;
`else
  logic w_unused_prev_lane;
  assign w_unused_prev_lane = ^r_prev_lane;
  assign w_lane = w_lane_map;
`endif

  always_comb begin
    case (w_lane)
      2'd0:    w_lane_x = LANE0_X;
      2'd2:    w_lane_x = LANE2_X;
      default: w_lane_x = LANE1_X;
    endcase
  end

  assign w_y_sum     = {1'b0, r_y} + {7'd0, r_speed};
  assign w_exit      = (w_y_sum >= {1'b0, SCREEN_H});
  assign w_pass_inc  = r_pass_cnt + 4'd1;
  assign w_speed_inc = (r_speed >= SPEED_MAX) ? SPEED_MAX : r_speed + 4'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_delay_nxt     = r_delay;
    w_pass_cnt_nxt  = r_pass_cnt;
    w_prev_lane_nxt = r_prev_lane;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_active_nxt    = r_active;
    w_passed_nxt    = 1'b0;
    w_speed_nxt     = r_speed;
    if (!run) begin
      w_state_nxt  = S_IDLE;
      w_active_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt    = S_WAIT;
          w_speed_nxt    = SPEED_INIT;
          w_pass_cnt_nxt = 4'd0;
          w_delay_nxt    = w_reload;
        end
        S_WAIT: begin
          if (r_tick) begin
            if (r_delay != 8'd0) begin
              w_delay_nxt = r_delay - 8'd1;
            end else begin
              w_x_nxt         = w_lane_x;
              w_y_nxt         = 10'd0;
              w_active_nxt    = 1'b1;
              w_prev_lane_nxt = w_lane;
              w_state_nxt     = S_FALL;
            end
          end
        end
        S_FALL: begin
          // hit outranks an exit on the same tick, so a struck rock never counts as passed
          if (hit) begin
            w_active_nxt = 1'b0;
            w_delay_nxt  = w_reload;
            w_state_nxt  = S_WAIT;
          end else if (r_tick) begin
            if (w_exit) begin
              w_active_nxt = 1'b0;
              w_passed_nxt = 1'b1;
              w_delay_nxt  = w_reload;
              w_state_nxt  = S_WAIT;
              if (w_pass_inc == SPEED_UP_EVERY) begin
                w_pass_cnt_nxt = 4'd0;
                w_speed_nxt    = w_speed_inc;
              end else begin
                w_pass_cnt_nxt = w_pass_inc;
              end
            end else begin
              w_y_nxt = w_y_sum[9:0];
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lfsr      <= LFSR_SEED;
      r_tick      <= 1'b0;
      r_delay     <= 8'd0;
      r_pass_cnt  <= 4'd0;
      r_prev_lane <= 2'd1;
      r_x         <= LANE1_X;
      r_y         <= 10'd0;
      r_active    <= 1'b0;
      r_passed    <= 1'b0;
      r_speed     <= SPEED_INIT;
    end else begin
      r_state     <= w_state_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_tick      <= (hCount == 10'd0) && (vCount == TICK_LINE);
      r_delay     <= w_delay_nxt;
      r_pass_cnt  <= w_pass_cnt_nxt;
      r_prev_lane <= w_prev_lane_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_active    <= w_active_nxt;
      r_passed    <= w_passed_nxt;
      r_speed     <= w_speed_nxt;
    end
  end

  assign rock_x_center = r_x;
  assign rock_y_top    = r_y;
  assign rock_active   = r_active;
  assign rock_passed   = r_passed;
  assign speed         = r_speed;

endmodule

// File: tb/tb_rock_spawner.sv
// Directed bench for rock_spawner: frame ticks are driven as single hCount/vCount match cycles.
module tb_rock_spawner;

  logic       clk;
  logic       rst_n;
  logic [9:0] h_cnt, v_cnt;
  logic       run, hit;
  logic [9:0] rock_x_center, rock_y_top;
  logic       rock_active, rock_passed;
  logic [3:0] speed;

  rock_spawner dut (
    .clk(clk), .rst_n(rst_n), .hCount(h_cnt), .vCount(v_cnt),
    .run(run), .hit(hit), .rock_x_center(rock_x_center),
    .rock_y_top(rock_y_top), .rock_active(rock_active),
    .rock_passed(rock_passed), .speed(speed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int my_y     = 0;
  int my_speed = 2;
  int passes   = 0;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       hit;
    logic       exp_active;
    int         exp_y;
    logic       exp_passed;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clk_step;
    @(posedge clk);
    #1;
    pulses += int'(rock_passed);
  endtask

  // one frame tick: a single matching cycle, then two idle cycles so the update is visible
  task automatic do_tick;
    h_cnt = 10'd0; v_cnt = 10'd480;
    clk_step();
    h_cnt = 10'd5; v_cnt = 10'd0;
    clk_step();
    clk_step();
  endtask

  task automatic wait_spawn;
    int n;
    n = 0;
    while (!rock_active && n < 70) begin
      do_tick();
      n++;
    end
    check("spawn_seen", int'(rock_active), 1);
    // delay is 30..61 ticks of countdown, so the spawn lands on tick 31..62
    check("spawn_delay_in_range", (n >= 31 && n <= 62) ? 1 : 0, 1);
    check("spawn_y", int'(rock_y_top), 0);
    check("spawn_lane_x", (rock_x_center == 10'd220 || rock_x_center == 10'd320 ||
                           rock_x_center == 10'd420) ? 1 : 0, 1);
    my_y = 0;
  endtask

  task automatic fall_to_exit;
    bit exp_exit;
    for (int g = 0; g < 300; g++) begin
      exp_exit = (my_y + my_speed >= 480);
      pulses = 0;
      do_tick();
      if (exp_exit) begin
        check("exit_active", int'(rock_active), 0);
        check("exit_pass_pulse_cycles", pulses, 1);
        check("exit_y_not_written", int'(rock_y_top), my_y);
        passes++;
        my_speed = (2 + passes / 4 > 8) ? 8 : 2 + passes / 4;
        check("speed_after_pass", int'(speed), my_speed);
        break;
      end
      my_y += my_speed;
      check("fall_y", rock_active ? int'(rock_y_top) : -1, my_y);
    end
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_x;
    int n_lanes;
    vecs[0] = '{10'd0, 10'd480, 1'b0, 1'b1, 0, 1'b0};
    vecs[1] = '{10'd5, 10'd0,   1'b0, 1'b1, 2, 1'b0};
    vecs[2] = '{10'd1, 10'd480, 1'b0, 1'b1, 2, 1'b0};
    vecs[3] = '{10'd0, 10'd479, 1'b0, 1'b1, 2, 1'b0};
    vecs[4] = '{10'd5, 10'd0,   1'b0, 1'b1, 2, 1'b0};
    vecs[5] = '{10'd0, 10'd480, 1'b0, 1'b1, 2, 1'b0};
    vecs[6] = '{10'd5, 10'd0,   1'b0, 1'b1, 4, 1'b0};
    vecs[7] = '{10'd5, 10'd0,   1'b1, 1'b0, 4, 1'b0};
    vecs[8] = '{10'd5, 10'd0,   1'b0, 1'b0, 4, 1'b0};
    vecs[9] = '{10'd5, 10'd0,   1'b1, 1'b0, 4, 1'b0};

    rst_n = 1'b0; run = 1'b1; hit = 1'b0; h_cnt = 10'd5; v_cnt = 10'd0;
    repeat (3) clk_step();
    check("rst_active", int'(rock_active), 0);
    check("rst_y", int'(rock_y_top), 0);
    check("rst_speed", int'(speed), 2);
    check("rst_x", int'(rock_x_center), 320);
    check("rst_passed", int'(rock_passed), 0);
    run = 1'b0;
    rst_n = 1'b1;
    repeat (40) do_tick();
    check("idle_stays_inactive", int'(rock_active), 0);

    run = 1'b1;
    wait_spawn();
    for (int i = 0; i < 10; i++) begin
      h_cnt = vecs[i].h; v_cnt = vecs[i].v; hit = vecs[i].hit;
      pulses = 0;
      clk_step();
      check($sformatf("vec%0d_active", i), int'(rock_active), int'(vecs[i].exp_active));
      check($sformatf("vec%0d_y", i), int'(rock_y_top), vecs[i].exp_y);
      check($sformatf("vec%0d_passed", i), pulses, int'(vecs[i].exp_passed));
    end
    hit = 1'b0; h_cnt = 10'd5; v_cnt = 10'd0;

    for (int k = 0; k < 3; k++) begin
      wait_spawn();
      fall_to_exit();
    end
    check("speed_before_ramp", int'(speed), 2);

    // hit lands on the same cycle the exit tick is processed
    wait_spawn();
    repeat (239) do_tick();
    check("pre_exit_y", int'(rock_y_top), 478);
    pulses = 0;
    h_cnt = 10'd0; v_cnt = 10'd480;
    clk_step();
    h_cnt = 10'd5; v_cnt = 10'd0; hit = 1'b1;
    clk_step();
    hit = 1'b0;
    clk_step();
    check("hit_exit_active", int'(rock_active), 0);
    check("hit_exit_no_pulse", pulses, 0);

    wait_spawn();
    fall_to_exit();
    check("speed_ramp_first", int'(speed), 3);
    while (passes < 28) begin
      wait_spawn();
      fall_to_exit();
    end
    check("speed_saturated", int'(speed), 8);

    wait_spawn();
    repeat (3) do_tick();
    run = 1'b0;
    pulses = 0;
    clk_step();
    check("run_drop_active", int'(rock_active), 0);
    repeat (3) do_tick();
    check("run_drop_no_pulse", pulses, 0);
    check("run_drop_stays_idle", int'(rock_active), 0);
    run = 1'b1;
    clk_step();
    check("rerun_speed_init", int'(speed), 2);
    my_speed = 2; passes = 0;

    wait_spawn();
    repeat (2) do_tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_active", int'(rock_active), 0);
    check("async_rst_y", int'(rock_y_top), 0);
    check("async_rst_x", int'(rock_x_center), 320);
    check("async_rst_speed", int'(speed), 2);
    @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef ROCK_LANE_AVOID_EN
    n_lanes = 200;
`else
    n_lanes = 25;
`endif
    prev_x = -1;
    for (int s = 0; s < n_lanes; s++) begin
      wait_spawn();
`ifdef ROCK_LANE_AVOID_EN
      if (prev_x >= 0) check("lane_differs", (int'(rock_x_center) != prev_x) ? 1 : 0, 1);
`endif
      prev_x = int'(rock_x_center);
      hit = 1'b1;
      clk_step();
      hit = 1'b0;
      check("lane_hit_retire", int'(rock_active), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
